// File: rtl/mips_pkg.sv
// Shared datapath widths and write-back control bundle for the lab MIPS pipeline.
package mips_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic valid;
    logic regwrite;
    logic memtoreg;
  } wb_ctrl_t;

endpackage

// File: rtl/retire_counter.sv
// Free-running event counter: adds one on each cycle where inc is high, wraps at 2^CNT_W.
module retire_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register driving the register-file write port, plus a retire counter.
// Defining WB_BYPASS_EN adds rs/rt compare outputs so ID can take WB data in the same cycle.
module mem_wb_writeback
  import mips_pkg::*;
#(
  parameter int DATA_W     = mips_pkg::DATA_W,
  parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_valid,
  input  logic                  mem_regwrite,
  input  logic                  mem_memtoreg,
  input  logic [DATA_W-1:0]     mem_alu_result,
  input  logic [DATA_W-1:0]     mem_read_data,
  input  logic [REG_ADDR_W-1:0] mem_write_reg,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  reg_write,
  output logic [REG_ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0]     write_data,
  output logic                  wb_valid,
  output logic [CNT_W-1:0]      retire_count
`ifdef WB_BYPASS_EN
  ,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  output logic                  fwd_a_hit,
  output logic                  fwd_b_hit,
  output logic [DATA_W-1:0]     fwd_data
`endif
);

  wb_ctrl_t mem_ctrl;

  logic                  wb_valid_q,   wb_valid_d;
  logic                  reg_write_q,  reg_write_d;
  logic [REG_ADDR_W-1:0] write_reg_q,  write_reg_d;
  logic [DATA_W-1:0]     write_data_q, write_data_d;
  logic                  write_done_q, write_done_d;
  logic                  retire_inc;

  assign mem_ctrl.valid    = mem_valid;
  assign mem_ctrl.regwrite = mem_regwrite;
  assign mem_ctrl.memtoreg = mem_memtoreg;

  always_comb begin
    wb_valid_d   = wb_valid_q;
    reg_write_d  = reg_write_q;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    write_done_d = write_done_q;
    if (flush) begin
      wb_valid_d   = 1'b0;
      reg_write_d  = 1'b0;
      write_done_d = 1'b0;
    end else if (stall) begin
      // A held instruction keeps its slot but its write port pulse is spent.
      reg_write_d  = 1'b0;
      write_done_d = 1'b1;
    end else begin
      wb_valid_d   = mem_ctrl.valid;
      write_reg_d  = mem_write_reg;
      write_data_d = mem_ctrl.memtoreg ? mem_read_data : mem_alu_result;
      reg_write_d  = mem_ctrl.valid & mem_ctrl.regwrite &
                     (mem_write_reg != REG_ADDR_W'(REG_ZERO));
      write_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid_q   <= 1'b0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      write_done_q <= 1'b0;
    end else begin
      wb_valid_q   <= wb_valid_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      write_done_q <= write_done_d;
    end
  end

  // Count in the instruction's first WB cycle only; later held cycles have write_done set.
  assign retire_inc = wb_valid_q & ~write_done_q;

  retire_counter #(
    .CNT_W(CNT_W)
  ) u_retire_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (retire_inc),
    .count (retire_count)
  );

  assign reg_write  = reg_write_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign wb_valid   = wb_valid_q;

`ifdef WB_BYPASS_EN
  assign fwd_a_hit = reg_write_q & (write_reg_q == rs_addr);
  assign fwd_b_hit = reg_write_q & (write_reg_q == rt_addr);
  assign fwd_data  = write_data_q;
`endif

endmodule
